regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port, single-write-port register file for the pipelined CPU series.
- Generalises the fixed 32x32 2R1W file in four ways:
  - configurable width, depth and read-port count
  - per-entry pending-write scoreboard for hazard detection in ID
  - sequential clear engine (FSM sweep) for soft reset without asserting rst
  - addressable debug read port in place of fixed register taps
- Sits between ID (reads, scoreboard set) and WB (writes).

Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of combinational read ports
- ZERO_REG, 1, 1 = entry 0 hardwired to zero, never written, never pending

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset
- ena  in  1  read enable; 0 forces every rdata lane to 0 (no tri-state)
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  read addresses, lane i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, lane i at bits [i*DATA_W +: DATA_W]
- rd_pending  out  NUM_RD  1 = lane i address has an outstanding producer
- sb_set  in  1  mark sb_addr pending (instruction issued with destination)
- sb_addr  in  ADDR_W  scoreboard set address
- clr_req  in  1  start clear sweep (level sampled in IDLE)
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  array[dbg_addr], combinational, ignores ena

Behaviour:
- Reset:
  - rst is asynchronous, active-high.
  - Clears all entries, all pending bits, FSM to IDLE, ptr to 0.
  - Outputs: clr_busy=0, clr_done=0, rd_pending=0, rdata=0.
- Write:
  - On rising clk, when we=1, FSM in IDLE, and !(ZERO_REG && waddr==0): array[waddr] <= wdata.
  - Write latency is 1 cycle; a same-cycle read returns the old value (see Optional Feature).
- Read: rdata lane i = ena ? array[raddr_i] : 0. Entry 0 reads 0 when ZERO_REG=1.
- Scoreboard, per entry, rising edge:
  - sb_set on the entry sets its pending bit.
  - An accepted write to the entry clears it.
  - Simultaneous sb_set and write to the same address: set wins.
  - sb_set to entry 0 is ignored when ZERO_REG=1.
  - sb_set is ignored while clr_busy=1.
- rd_pending lane i = pending[raddr_i]; not gated by ena.
- Clear FSM:
  - IDLE: when clr_req=1, go to SWEEP with ptr=0; all pending bits cleared on the same edge.
  - SWEEP: array[ptr] <= 0 each cycle; ptr increments. When ptr==DEPTH-1, go to DONE. Takes exactly DEPTH cycles.
  - DONE: clr_done=1 for one cycle, then IDLE. clr_req held high causes a new sweep from the following IDLE cycle.
  - clr_busy=1 in SWEEP and DONE.
  - External writes (we) are dropped, not queued, in SWEEP and DONE.
  - Reads return live array contents throughout the sweep.
  - clr_req is ignored outside IDLE.
- ptr wraps naturally at ADDR_W bits; it is reset to 0 on entry to SWEEP.
- rst asserted mid-sweep aborts immediately to reset state; clr_done does not pulse.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When we=1, FSM in IDLE, waddr==raddr_i and the address is not hardwired zero, lane i rdata = wdata (still gated by ena), and rd_pending lane i = 0 unless sb_set targets the same address this cycle. dbg_data is not bypassed.
- Undefined: rdata comes purely from array contents; same-cycle read-after-write returns the old value.

Decomposition:
- Package regfile_pkg:
  - clear FSM state enum {IDLE, SWEEP, DONE}
  - default DATA_W/ADDR_W constants
  - function for lane slicing offsets
- One sub-module, regfile_scoreboard: the DEPTH pending bits with set/clear/clear-all inputs and NUM_RD lookup outputs.
- Array, write logic and clear FSM stay in regfile_mp.

Test Plan:
- Write/read: we=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr lane0=5, ena=1 -> rdata lane0=0xDEADBEEF. Same with ena=0 -> 0.
- Zero register: ZERO_REG=1, write 0x12345678 to addr 0 -> rdata=0, dbg_data=0. sb_set addr 0 -> rd_pending=0.
- Scoreboard: sb_set addr 7 -> rd_pending lane1 (raddr=7)=1. Cycle with sb_set=7 and we to 7 -> stays 1. Later plain write to 7 -> 0.
- Clear sweep, DEPTH=32, entries preloaded:
  - Pulse clr_req -> clr_busy high for 33 cycles.
  - clr_done pulses exactly 33 cycles after the clr_req edge.
  - A write issued mid-sweep is lost.
  - All entries read 0 afterwards.
- Reset mid-sweep: assert rst at sweep cycle 10 -> clr_busy=0 immediately, all entries 0, no clr_done pulse.
- Bypass (macro defined): we=1, waddr=3, wdata=0xA5A5A5A5, raddr=3 same cycle -> rdata=0xA5A5A5A5. Macro undefined -> old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Low bit of lane `lane` inside a packed multi-lane bus of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry pending-write bits: set on issue, cleared by retiring write, bulk-cleared by the sweep.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic                     clr_i,
  input  logic [ADDR_W-1:0]        clr_addr_i,
  input  logic                     clr_all_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD-1:0]        pending_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Set is applied after clear so an issue racing a retire stays pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_all_i) begin
      pend_d = '0;
    end else begin
      if (clr_i) pend_d[clr_addr_i] = 1'b0;
      if (set_i) pend_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_lookup
    assign pending_o[g] = pend_q[raddr_i[lane_lo(g, ADDR_W) +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_mp.sv
// NUM_RD-read / 1-write register file with hazard scoreboard, clear sweep and debug port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read lanes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic idle, wr_acc, sb_acc, clr_start, sweep_wr;
  logic [NUM_RD-1:0] sb_pend;

  assign idle      = (state_q == IDLE);
  assign wr_acc    = we && idle && !((ZERO_REG != 0) && (waddr == '0));
  assign sb_acc    = sb_set && !clr_busy && !((ZERO_REG != 0) && (sb_addr == '0));
  assign clr_start = idle && clr_req;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    sweep_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        clr_busy = 1'b1;
        sweep_wr = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) state_d = DONE;
      end
      DONE: begin
        clr_busy = 1'b1;
        clr_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep and external writes never coincide: writes are only accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (sweep_wr) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr] <= wdata;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_acc),
    .set_addr_i (sb_addr),
    .clr_i      (wr_acc),
    .clr_addr_i (waddr),
    .clr_all_i  (clr_start),
    .raddr_i    (raddr),
    .pending_o  (sb_pend)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_lane
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] arr_val;
    assign ra      = raddr[lane_lo(g, ADDR_W) +: ADDR_W];
    assign arr_val = ((ZERO_REG != 0) && (ra == '0)) ? '0 : mem_q[ra];
`ifdef REGFILE_BYPASS_EN
    logic byp_hit;
    // wr_acc already excludes the hardwired-zero entry.
    assign byp_hit = wr_acc && (waddr == ra);
    assign rdata[lane_lo(g, DATA_W) +: DATA_W] = !ena ? '0 : (byp_hit ? wdata : arr_val);
    assign rd_pending[g] = byp_hit ? (sb_acc && (sb_addr == ra)) : sb_pend[g];
`else
    assign rdata[lane_lo(g, DATA_W) +: DATA_W] = ena ? arr_val : '0;
    assign rd_pending[g] = sb_pend[g];
`endif
  end

  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp at default parameters (32x32, 2 read lanes, ZERO_REG=1).
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     ena = 1'b0;
  logic                     we = 1'b0;
  logic [ADDR_W-1:0]        waddr = '0;
  logic [DATA_W-1:0]        wdata = '0;
  logic [NUM_RD*ADDR_W-1:0] raddr = '0;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     sb_set = 1'b0;
  logic [ADDR_W-1:0]        sb_addr = '0;
  logic                     clr_req = 1'b0;
  logic                     clr_busy;
  logic                     clr_done;
  logic [ADDR_W-1:0]        dbg_addr = '0;
  logic [DATA_W-1:0]        dbg_data;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_v;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rd_pending (rd_pending),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic set_raddr(input int lane, input logic [ADDR_W-1:0] a);
    raddr[lane*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [DATA_W-1:0] lane_data(input int lane);
    return rdata[lane*DATA_W +: DATA_W];
  endfunction

  // One accepted write in IDLE; returns just after the following negedge.
  task automatic write_cyc(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    if (a != '0) mem_m[a] = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    rst = 1'b1; ena = 1'b1;
    set_raddr(0, 5'd5); set_raddr(1, 5'd31); dbg_addr = 5'd17;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", clr_done); end
    checks++; if (rd_pending !== 2'b00) begin errors++; $display("FAIL reset_pending got %b want 00", rd_pending); end
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg got %h want 0", dbg_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [ADDR_W-1:0] a;
    write_cyc(5'd5, 32'hDEADBEEF);
    set_raddr(0, 5'd5); ena = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    #1; exp_v = exp_q.pop_front();
    checks++; if (lane_data(0) !== exp_v) begin errors++; $display("FAIL wr_rd_lane0 got %h want %h", lane_data(0), exp_v); end
    ena = 1'b0; dbg_addr = 5'd5;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hDEADBEEF);
    #1; exp_v = exp_q.pop_front();
    checks++; if (lane_data(0) !== exp_v) begin errors++; $display("FAIL ena_low got %h want %h", lane_data(0), exp_v); end
    exp_v = exp_q.pop_front();
    checks++; if (dbg_data !== exp_v) begin errors++; $display("FAIL dbg_ignores_ena got %h want %h", dbg_data, exp_v); end
    ena = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) write_cyc(ADDR_W'(k*4+2), $urandom);
    for (int k = 1; k <= 6; k += 2) begin
      set_raddr(0, ADDR_W'(k*4+2));
      set_raddr(1, ADDR_W'((k+1)*4+2));
      exp_q.push_back(mem_m[k*4+2]);
      exp_q.push_back(mem_m[(k+1)*4+2]);
      #1;
      for (int l = 0; l < NUM_RD; l++) begin
        exp_v = exp_q.pop_front();
        a = raddr[l*ADDR_W +: ADDR_W];
        checks++; if (lane_data(l) !== exp_v) begin errors++; $display("FAIL rd_pattern lane%0d addr%0d got %h want %h", l, a, lane_data(l), exp_v); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_reg();
    write_cyc(5'd0, 32'h12345678);
    set_raddr(0, 5'd0); dbg_addr = 5'd0; ena = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1; exp_v = exp_q.pop_front();
    checks++; if (lane_data(0) !== exp_v) begin errors++; $display("FAIL zero_rdata got %h want %h", lane_data(0), exp_v); end
    exp_v = exp_q.pop_front();
    checks++; if (dbg_data !== exp_v) begin errors++; $display("FAIL zero_dbg got %h want %h", dbg_data, exp_v); end
    sb_set = 1'b1; sb_addr = 5'd0;
    @(negedge clk);
    sb_set = 1'b0;
    #1;
    checks++; if (rd_pending[0] !== 1'b0) begin errors++; $display("FAIL zero_pending got %b want 0", rd_pending[0]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    set_raddr(0, 5'd5); set_raddr(1, 5'd7);
    sb_set = 1'b1; sb_addr = 5'd7;
    @(negedge clk);
    sb_set = 1'b0;
    #1;
    checks++; if (rd_pending[1] !== 1'b1) begin errors++; $display("FAIL sb_set got %b want 1", rd_pending[1]); end
    checks++; if (rd_pending[0] !== 1'b0) begin errors++; $display("FAIL sb_other_lane got %b want 0", rd_pending[0]); end
    sb_set = 1'b1; sb_addr = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0077;
    @(negedge clk);
    sb_set = 1'b0; we = 1'b0; mem_m[7] = 32'h0000_0077;
    exp_q.push_back(mem_m[7]);
    #1;
    checks++; if (rd_pending[1] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", rd_pending[1]); end
    exp_v = exp_q.pop_front();
    checks++; if (lane_data(1) !== exp_v) begin errors++; $display("FAIL sb_race_data got %h want %h", lane_data(1), exp_v); end
    write_cyc(5'd7, 32'h0000_1234);
    #1;
    checks++; if (rd_pending[1] !== 1'b0) begin errors++; $display("FAIL sb_write_clears got %b want 0", rd_pending[1]); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    write_cyc(5'd3, 32'h1111_1111);
    set_raddr(0, 5'd3); ena = 1'b1;
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(mem_m[3]);
`endif
    #1; exp_v = exp_q.pop_front();
    checks++; if (lane_data(0) !== exp_v) begin errors++; $display("FAIL same_cycle_raw got %h want %h", lane_data(0), exp_v); end
    @(negedge clk);
    we = 1'b0; mem_m[3] = 32'hA5A5A5A5;
    exp_q.push_back(mem_m[3]);
    #1; exp_v = exp_q.pop_front();
    checks++; if (lane_data(0) !== exp_v) begin errors++; $display("FAIL raw_next_cycle got %h want %h", lane_data(0), exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] prev;
    @(negedge clk);
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      we = 1'b1; waddr = ADDR_W'(16 + k); wdata = $urandom;
      if (k > 0) begin
        set_raddr(1, prev);
        exp_q.push_back(mem_m[prev]);
        #1; exp_v = exp_q.pop_front();
        checks++; if (lane_data(1) !== exp_v) begin errors++; $display("FAIL b2b k%0d got %h want %h", k, lane_data(1), exp_v); end
      end
      @(negedge clk);
      mem_m[16 + k] = wdata;
      prev = ADDR_W'(16 + k);
    end
    we = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cnt, done_at, done_cnt, n;
    logic finished;
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd2;
    @(negedge clk);
    sb_set = 1'b0; set_raddr(0, 5'd2);
    #1;
    checks++; if (rd_pending[0] !== 1'b1) begin errors++; $display("FAIL pre_clear_pending got %b want 1", rd_pending[0]); end
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    busy_cnt = 0; done_at = 0; done_cnt = 0; finished = 1'b0;
    for (n = 1; n <= 60; n++) begin
      if (n == 6)  begin sb_set = 1'b1; sb_addr = 5'd12; end
      if (n == 20) begin we = 1'b1; waddr = 5'd3;  wdata = 32'hFFFF_0000; end
      if (n == 33) begin we = 1'b1; waddr = 5'd4;  wdata = 32'h0F0F_0F0F; end
      #1;
      if (n == 1) begin
        checks++; if (rd_pending[0] !== 1'b0) begin errors++; $display("FAIL clear_all_pending got %b want 0", rd_pending[0]); end
      end
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; if (done_at == 0) done_at = n; end
      if (!clr_busy) begin finished = 1'b1; break; end
      @(negedge clk);
      we = 1'b0; sb_set = 1'b0;
    end
    we = 1'b0; sb_set = 1'b0;
    checks++; if (!finished) begin errors++; $display("FAIL sweep_timeout busy_cycles %0d limit 60", busy_cnt); end
    checks++; if (busy_cnt != 33) begin errors++; $display("FAIL busy_cycles got %0d want 33", busy_cnt); end
    checks++; if (done_at != 33) begin errors++; $display("FAIL done_cycle got %0d want 33", done_at); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_pulses got %0d want 1", done_cnt); end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    set_raddr(1, 5'd12);
    #1;
    checks++; if (rd_pending[1] !== 1'b0) begin errors++; $display("FAIL sb_during_sweep got %b want 0", rd_pending[1]); end
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = ADDR_W'(i);
      set_raddr(0, ADDR_W'(i));
      exp_q.push_back(mem_m[i]);
      #1; exp_v = exp_q.pop_front();
      checks++; if (dbg_data !== exp_v || lane_data(0) !== exp_v) begin
        errors++; $display("FAIL post_sweep addr%0d dbg %h rd %h want %h", i, dbg_data, lane_data(0), exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    @(negedge clk);
    write_cyc(5'd9, 32'h9999_9999);
    write_cyc(5'd20, 32'h2020_2020);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; dbg_addr = 5'd20;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    exp_q.push_back(mem_m[20]);
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy got %b want 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL rst_abort_done got %b want 0", clr_done); end
    exp_v = exp_q.pop_front();
    checks++; if (dbg_data !== exp_v) begin errors++; $display("FAIL rst_abort_entry got %h want %h", dbg_data, exp_v); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_done got %0d busy/done cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
